// File: rtl/word_msb_serializer.sv
// rtl/word_msb_serializer.sv - MSB-first word serializer feeding the serial divisibility checker.
// Optional SER_STALL_EN adds a bit_ready input that stalls the shift phase.
module word_msb_serializer #(
  parameter int W   = 8,
  parameter int GAP = 1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
`ifdef SER_STALL_EN
  input  logic         bit_ready,
`endif
  output logic         bit_valid,
  output logic         bit_out,
  output logic         bit_first,
  output logic         bit_last,
  output logic         chk_clr_n,
  output logic         res_sample,
  output logic         busy,
  output logic [15:0]  word_cnt
);

  localparam int BW = $clog2(W);
  localparam int GW = $clog2(GAP + 1);
  localparam logic [BW-1:0] BCNT_LAST = BW'(W - 1);
  localparam logic [GW-1:0] GCNT_LAST = GW'(GAP - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLR   = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  sreg_q, sreg_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [15:0]   word_cnt_q, word_cnt_d;
  logic          res_sample_q, res_sample_d;
  logic          rdy;
  logic          acc;

`ifdef SER_STALL_EN
  assign rdy = bit_ready;
`else
  assign rdy = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= IDLE;
      sreg_q       <= '0;
      gcnt_q       <= '0;
      bcnt_q       <= '0;
      word_cnt_q   <= '0;
      res_sample_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sreg_q       <= sreg_d;
      gcnt_q       <= gcnt_d;
      bcnt_q       <= bcnt_d;
      word_cnt_q   <= word_cnt_d;
      res_sample_q <= res_sample_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sreg_d     = sreg_q;
    gcnt_d     = gcnt_q;
    bcnt_d     = bcnt_q;
    word_cnt_d = word_cnt_q;
    in_ready   = 1'b0;
    bit_valid  = 1'b0;
    bit_out    = 1'b0;
    bit_first  = 1'b0;
    bit_last   = 1'b0;
    chk_clr_n  = 1'b1;
    acc        = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          sreg_d  = in_data;
          gcnt_d  = '0;
          bcnt_d  = '0;
          state_d = CLR;
        end
      end

      CLR: begin
        chk_clr_n = 1'b0;
        gcnt_d    = gcnt_q + GW'(1);
        if (gcnt_q == GCNT_LAST) begin
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        bit_valid = 1'b1;
        bit_out   = sreg_q[W-1];
        bit_first = (bcnt_q == '0);
        bit_last  = (bcnt_q == BCNT_LAST);
        acc       = rdy;
        if (acc) begin
          sreg_d = sreg_q << 1;
          bcnt_d = bcnt_q + BW'(1);
          if (bit_last) begin
            word_cnt_d = word_cnt_q + 16'd1;
            in_ready   = 1'b1;
            bcnt_d     = '0;
            // Back-to-back words skip IDLE so the gap stays exactly GAP cycles.
            if (in_valid) begin
              sreg_d  = in_data;
              gcnt_d  = '0;
              state_d = CLR;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Delayed one cycle so the checker has absorbed the LSB before dout is sampled.
  assign res_sample_d = acc & bit_last;

  assign res_sample = res_sample_q;
  assign busy       = (state_q != IDLE);
  assign word_cnt   = word_cnt_q;

endmodule

// File: tb/tb_word_msb_serializer.sv
// tb/tb_word_msb_serializer.sv - directed scoreboard bench for word_msb_serializer with a mod-4 checker model.
module tb_word_msb_serializer;

  logic        clk;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        bit_ready_t;
  logic        bit_valid;
  logic        bit_out;
  logic        bit_first;
  logic        bit_last;
  logic        chk_clr_n;
  logic        res_sample;
  logic        busy;
  logic [15:0] word_cnt;

  logic        in_valid2;
  logic        in_ready2;
  logic [1:0]  in_data2;
  logic        bit_valid2;
  logic        bit_out2;
  logic        bit_first2;
  logic        bit_last2;
  logic        chk_clr_n2;
  logic        res_sample2;
  logic        busy2;
  logic [15:0] word_cnt2;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] sb[$];
  logic [7:0] col;
  logic [1:0] chk_r;
  logic [1:0] chk2_r;
  logic       dout;
  logic       dout2;

  word_msb_serializer #(.W(8), .GAP(1)) u_dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
`ifdef SER_STALL_EN
    .bit_ready  (bit_ready_t),
`endif
    .bit_valid  (bit_valid),
    .bit_out    (bit_out),
    .bit_first  (bit_first),
    .bit_last   (bit_last),
    .chk_clr_n  (chk_clr_n),
    .res_sample (res_sample),
    .busy       (busy),
    .word_cnt   (word_cnt)
  );

  word_msb_serializer #(.W(2), .GAP(3)) u_dut2 (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid2),
    .in_ready   (in_ready2),
    .in_data    (in_data2),
`ifdef SER_STALL_EN
    .bit_ready  (1'b1),
`endif
    .bit_valid  (bit_valid2),
    .bit_out    (bit_out2),
    .bit_first  (bit_first2),
    .bit_last   (bit_last2),
    .chk_clr_n  (chk_clr_n2),
    .res_sample (res_sample2),
    .busy       (busy2),
    .word_cnt   (word_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Divide-by-4 checker: residue of the MSB-first bit stream, cleared via resetn & chk_clr_n.
  always @(posedge clk) begin
    if (!(resetn && chk_clr_n)) chk_r <= 2'd0;
    else if (bit_valid && bit_ready_t) chk_r <= {chk_r[0], bit_out};
    if (!(resetn && chk_clr_n2)) chk2_r <= 2'd0;
    else if (bit_valid2) chk2_r <= {chk2_r[0], bit_out2};
  end
  assign dout  = (chk_r == 2'd0);
  assign dout2 = (chk2_r == 2'd0);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: push on word accept, rebuild word from bits, pop and compare at res_sample.
  always @(negedge clk) begin
    logic [7:0] exp_w;
    if (resetn && in_valid && in_ready) sb.push_back(in_data);
    if (bit_valid && bit_ready_t) begin
      if (bit_first) col = {7'd0, bit_out};
      else col = {col[6:0], bit_out};
    end
    if (res_sample) begin
      check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        exp_w = sb.pop_front();
        check("sb_word", 32'(col), 32'(exp_w));
        check("sb_dout", 32'(dout), 32'(exp_w[1:0] == 2'b00));
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    resetn   = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    sb.delete();
  endtask

  task automatic single_word(input logic [7:0] d, input int exp_cnt);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    check("idle_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    @(negedge clk);
    check("clr_n_low", 32'(chk_clr_n), 32'd0);
    check("clr_valid", 32'(bit_valid), 32'd0);
    check("clr_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("bit_out", 32'(bit_out), 32'(d[7-i]));
      check("bit_first", 32'(bit_first), 32'(i == 0));
      check("bit_last", 32'(bit_last), 32'(i == 7));
      check("shift_ready", 32'(in_ready), 32'(i == 7));
    end
    @(negedge clk);
    check("res_pulse", 32'(res_sample), 32'd1);
    check("word_cnt", 32'(word_cnt), 32'(exp_cnt));
    check("idle_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("res_one_cycle", 32'(res_sample), 32'd0);
  endtask

  initial begin
    logic [7:0] d;
    int k;
    resetn      = 1'b0;
    in_valid    = 1'b0;
    in_data     = 8'd0;
    bit_ready_t = 1'b1;
    in_valid2   = 1'b0;
    in_data2    = 2'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_bit_valid", 32'(bit_valid), 32'd0);
    check("rst_bit_out", 32'(bit_out), 32'd0);
    check("rst_bit_first", 32'(bit_first), 32'd0);
    check("rst_bit_last", 32'(bit_last), 32'd0);
    check("rst_chk_clr_n", 32'(chk_clr_n), 32'd1);
    check("rst_res_sample", 32'(res_sample), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_word_cnt", 32'(word_cnt), 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;

    single_word(8'h0C, 1);
    do_reset();
    single_word(8'h0D, 1);

    // Back-to-back 0xFF then 0x04 with in_valid held.
    do_reset();
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    @(posedge clk); #1;
    in_data = 8'h04;
    @(negedge clk);
    check("b2b_clr1", 32'(chk_clr_n), 32'd0);
    check("b2b_clr1_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("b2b_bit1", 32'(bit_out), 32'd1);
      check("b2b_ready1", 32'(in_ready), 32'(i == 7));
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("b2b_clr2", 32'(chk_clr_n), 32'd0);
    check("b2b_res1", 32'(res_sample), 32'd1);
    d = 8'h04;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("b2b_clr_gap", 32'(chk_clr_n), 32'd1);
      check("b2b_bit2", 32'(bit_out), 32'(d[7-i]));
      check("b2b_first2", 32'(bit_first), 32'(i == 0));
    end
    @(negedge clk);
    check("b2b_res2", 32'(res_sample), 32'd1);
    check("b2b_word_cnt", 32'(word_cnt), 32'd2);

    // Reset after 3 bits of 0xA5 aborts the word.
    do_reset();
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = 8'hA5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_mid_valid", 32'(bit_valid), 32'd1);
    @(posedge clk); #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    sb.delete();
    @(negedge clk);
    check("abort_bit_valid", 32'(bit_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_word_cnt", 32'(word_cnt), 32'd0);
    check("abort_res", 32'(res_sample), 32'd0);
    single_word(8'h08, 1);

`ifdef SER_STALL_EN
    // 0x30 with bit_ready low for 3 cycles at the fourth bit.
    do_reset();
    d = 8'h30;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("stall_clr", 32'(chk_clr_n), 32'd0);
    for (int c = 0; c < 11; c++) begin
      @(posedge clk); #1;
      bit_ready_t = !(c >= 3 && c < 6);
      k = (c < 3) ? c : ((c < 6) ? 3 : c - 3);
      @(negedge clk);
      check("stall_bit_out", 32'(bit_out), 32'(d[7-k]));
      check("stall_first", 32'(bit_first), 32'(k == 0));
      check("stall_last", 32'(bit_last), 32'(k == 7));
    end
    @(posedge clk); #1;
    bit_ready_t = 1'b1;
    @(negedge clk);
    check("stall_res", 32'(res_sample), 32'd1);
    check("stall_word_cnt", 32'(word_cnt), 32'd1);
`endif

    // W=2, GAP=3 instance: 0b10.
    do_reset();
    @(posedge clk); #1;
    in_valid2 = 1'b1;
    in_data2  = 2'b10;
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("g3_clr_n", 32'(chk_clr_n2), 32'd0);
      check("g3_valid", 32'(bit_valid2), 32'd0);
    end
    @(negedge clk);
    check("g3_bit0", 32'(bit_out2), 32'd1);
    check("g3_first", 32'(bit_first2), 32'd1);
    @(negedge clk);
    check("g3_bit1", 32'(bit_out2), 32'd0);
    check("g3_last", 32'(bit_last2), 32'd1);
    @(negedge clk);
    check("g3_res", 32'(res_sample2), 32'd1);
    check("g3_dout", 32'(dout2), 32'(2 % 4 == 0));
    check("g3_word_cnt", 32'(word_cnt2), 32'd1);

    @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
